// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: START, device id, register address, data, STOP, paced by divClock ticks.
// Define SCCB_ACK_CHECK_EN to sample siodIn in each ACK slot into the sticky nack flag.
module sccb_write_master #(
    parameter logic [7:0] DeviceId = 8'h42
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       divClock,
    input  logic       start,
    input  logic [7:0] regAddr,
    input  logic [7:0] regData,
    input  logic       siodIn,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       sioc,
    output logic       siod,
    output logic       siodOe
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_PH1   = 3'd2;
    localparam logic [2:0] ST_PH2   = 3'd3;
    localparam logic [2:0] ST_PH3   = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;
    localparam logic [2:0] ST_FIN   = 3'd6;

    logic [2:0] state, nextState;
    logic [1:0] q, nextQ;
    logic [3:0] b, nextB;
    logic       divClockQ;
    logic       tick;
    logic       acceptStart;
    logic       inPhase;
    logic [7:0] addrReg, dataReg;
    logic [7:0] lineByte;
    logic       nextSioc, nextSiod, nextOe;

    assign tick        = divClock & ~divClockQ;
    assign acceptStart = (state == ST_IDLE) && start;
    assign inPhase     = (state == ST_PH1) || (state == ST_PH2) || (state == ST_PH3);

    always_comb begin
        nextState = state;
        nextQ     = q;
        nextB     = b;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nextState = ST_START;
                    nextQ     = 2'd0;
                    nextB     = 4'd0;
                end
            end
            ST_FIN: nextState = ST_IDLE;
            default: begin
                if (tick) begin
                    nextQ = q + 2'd1;
                    if (q == 2'd3) begin
                        case (state)
                            ST_START: nextState = ST_PH1;
                            ST_PH1, ST_PH2, ST_PH3: begin
                                if (b == 4'd8) begin
                                    nextB     = 4'd0;
                                    nextState = (state == ST_PH3) ? ST_STOP : state + 3'd1;
                                end else begin
                                    nextB = b + 4'd1;
                                end
                            end
                            ST_STOP: nextState = ST_FIN;
                            default: nextState = ST_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Pin levels are derived from the upcoming quarter so they register glitch-free; unlisted levels hold.
    always_comb begin
        nextSioc = sioc;
        nextSiod = siod;
        nextOe   = siodOe;
        case (nextState)
            ST_PH1:  lineByte = DeviceId;
            ST_PH2:  lineByte = addrReg;
            default: lineByte = dataReg;
        endcase
        case (nextState)
            ST_START: begin
                case (nextQ)
                    2'd0: begin
                        nextSioc = 1'b1;
                        nextSiod = 1'b1;
                        nextOe   = 1'b1;
                    end
                    2'd1, 2'd2: nextSiod = 1'b0;
                    default:    nextSioc = 1'b0;
                endcase
            end
            ST_PH1, ST_PH2, ST_PH3: begin
                case (nextQ)
                    2'd0: begin
                        nextSioc = 1'b0;
                        nextOe   = 1'b1;
                    end
                    2'd1: begin
                        if (nextB == 4'd8) begin
                            nextSiod = 1'b1;
                            nextOe   = 1'b0;
                        end else begin
                            nextSiod = lineByte[~nextB[2:0]];
                            nextOe   = 1'b1;
                        end
                    end
                    default: nextSioc = 1'b1;
                endcase
            end
            ST_STOP: begin
                case (nextQ)
                    2'd0, 2'd1: begin
                        nextSioc = 1'b0;
                        nextSiod = 1'b0;
                        nextOe   = 1'b1;
                    end
                    2'd2:    nextSioc = 1'b1;
                    default: nextSiod = 1'b1;
                endcase
            end
            default: begin
                nextSioc = 1'b1;
                nextSiod = 1'b1;
                nextOe   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            q         <= 2'd0;
            b         <= 4'd0;
            divClockQ <= 1'b0;
            addrReg   <= 8'h00;
            dataReg   <= 8'h00;
            sioc      <= 1'b1;
            siod      <= 1'b1;
            siodOe    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            nack      <= 1'b0;
        end else begin
            state     <= nextState;
            q         <= nextQ;
            b         <= nextB;
            divClockQ <= divClock;
            sioc      <= nextSioc;
            siod      <= nextSiod;
            siodOe    <= nextOe;
            busy      <= (nextState != ST_IDLE) && (nextState != ST_FIN);
            done      <= (nextState == ST_FIN);
            if (acceptStart) begin
                addrReg <= regAddr;
                dataReg <= regData;
            end
            if (acceptStart) begin
                nack <= 1'b0;
            end
`ifdef SCCB_ACK_CHECK_EN
            else if (tick && inPhase && (b == 4'd8) && (q == 2'd3) && siodIn) begin
                nack <= 1'b1;
            end
`endif
        end
    end

`ifdef SCCB_ACK_CHECK_EN
`else
    logic unusedAckInputs;
    assign unusedAckInputs = siodIn | inPhase;
`endif

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master: decodes the SIOC/SIOD waveform and checks frames, timing and nack.
module tb_sccb_write_master;

    logic       clock;
    logic       reset;
    logic       divClock;
    logic       start;
    logic [7:0] regAddr;
    logic [7:0] regData;
    logic       siodIn;
    logic       busy, done, nack, sioc, siod, siodOe;

`ifdef SCCB_ACK_CHECK_EN
    localparam logic ExpNack = 1'b1;
`else
    localparam logic ExpNack = 1'b0;
`endif

    int  checkCount = 0;
    int  failCount  = 0;
    int  tickCount  = 0;
    int  cycleNo    = 0;
    int  riseCount  = 0;
    int  startSeen  = 0;
    int  stopSeen   = 0;
    int  doneCount  = 0;
    int  doneTick   = 0;
    int  doneCycle  = 0;
    int  busyRiseCycle = 0;
    int  oeFallCount = 0;
    logic nackAtDone = 1'b0;
    logic riseSiod [1024];
    logic riseOe   [1024];
    logic ackMode  = 1'b0;
    int  ackBase   = 0;

    int  frameRise, frameTick, frameStart, frameStop, frameDone;

    sccb_write_master #(.DeviceId(8'h42)) dut (
        .clock(clock), .reset(reset), .divClock(divClock), .start(start),
        .regAddr(regAddr), .regData(regData), .siodIn(siodIn),
        .busy(busy), .done(done), .nack(nack),
        .sioc(sioc), .siod(siod), .siodOe(siodOe)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // divClock period is 4 system clocks; every rising edge is one tick
    initial begin
        int halfCnt;
        halfCnt  = 0;
        divClock = 1'b0;
        forever begin
            @(negedge clock);
            halfCnt++;
            if (halfCnt == 2) begin
                halfCnt  = 0;
                divClock = ~divClock;
                if (divClock) tickCount++;
            end
        end
    end

    // Sensor model: pull ACK high only in the PH2 ack slot when ackMode is on
    initial begin
        siodIn = 1'b0;
        forever begin
            @(negedge clock);
            siodIn = ackMode && !siodOe && ((oeFallCount - ackBase) == 2);
        end
    end

    initial begin
        logic prevSioc, prevSiod, prevOe, prevBusy;
        prevSioc = 1'b1; prevSiod = 1'b1; prevOe = 1'b1; prevBusy = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cycleNo++;
            if (!prevSioc && sioc && riseCount < 1024) begin
                riseSiod[riseCount] = siod;
                riseOe[riseCount]   = siodOe;
                riseCount++;
            end
            if (prevSioc && sioc && prevSiod && !siod) startSeen++;
            if (prevSioc && sioc && !prevSiod && siod) stopSeen++;
            if (prevOe && !siodOe) oeFallCount++;
            if (done) begin
                doneCount++;
                doneTick   = tickCount;
                doneCycle  = cycleNo;
                nackAtDone = nack;
            end
            if (!prevBusy && busy) busyRiseCycle = cycleNo;
            prevSioc = sioc; prevSiod = siod; prevOe = siodOe; prevBusy = busy;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic snapshot();
        frameRise  = riseCount;
        frameTick  = tickCount;
        frameStart = startSeen;
        frameStop  = stopSeen;
        frameDone  = doneCount;
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data, input string tag);
        @(negedge clock);
        regAddr = addr;
        regData = data;
        start   = 1'b1;
        @(posedge clock);
        #2;
        snapshot();
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitDone(input int target, input string tag);
        for (int i = 0; i < 3000 && doneCount < target; i++) begin
            @(posedge clock);
            #2;
        end
        checkOutput({tag, "_doneSeen"}, {31'd0, doneCount >= target}, 32'd1);
    endtask

    task automatic waitTicks(input int n);
        for (int i = 0; i < 3000 && (tickCount - frameTick) < n; i++) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic checkFrame(input int base, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, input string tag);
        logic [7:0]  bytes [3];
        logic [26:0] oeVec;
        oeVec = '0;
        for (int p = 0; p < 3; p++) begin
            bytes[p] = 8'h00;
            for (int i = 0; i < 8; i++) bytes[p] = {bytes[p][6:0], riseSiod[base + p * 9 + i]};
            for (int i = 0; i < 9; i++) oeVec = {oeVec[25:0], riseOe[base + p * 9 + i]};
        end
        checkOutput({tag, "_dev"},  {24'd0, bytes[0]}, {24'd0, e1});
        checkOutput({tag, "_addr"}, {24'd0, bytes[1]}, {24'd0, e2});
        checkOutput({tag, "_data"}, {24'd0, bytes[2]}, {24'd0, e3});
        checkOutput({tag, "_oe"},   {5'd0, oeVec}, {5'd0, 27'b111111110_111111110_111111110});
        checkOutput({tag, "_stopLow"}, {31'd0, riseSiod[base + 27]}, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        regAddr = 8'h00;
        regData = 8'h00;

        // reset held 3 cycles: idle lines throughout
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #2;
            checkOutput($sformatf("resetIdle%0d", i), {26'd0, sioc, siod, siodOe, busy, done, nack},
                        {26'd0, 6'b111000});
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // single write
        applyStimulus(8'h12, 8'h80, "single");
        waitDone(frameDone + 1, "single");
        checkOutput("single_ticks", doneTick - frameTick, 32'd116);
        checkOutput("single_start", startSeen - frameStart, 32'd1);
        checkOutput("single_stop", stopSeen - frameStop, 32'd1);
        checkOutput("single_rises", riseCount - frameRise, 32'd28);
        checkOutput("single_busyEnd", {31'd0, busy}, 32'd0);
        checkFrame(frameRise, 8'h42, 8'h12, 8'h80, "single");
        repeat (20) @(negedge clock);
        checkOutput("single_doneOnce", doneCount - frameDone, 32'd1);

        // start mid-PH2 must be ignored
        applyStimulus(8'h12, 8'h80, "ignored");
        waitTicks(50);
        @(negedge clock);
        regAddr = 8'hFF;
        regData = 8'hFF;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitDone(frameDone + 1, "ignored");
        checkFrame(frameRise, 8'h42, 8'h12, 8'h80, "ignored");
        repeat (100) @(negedge clock);
        checkOutput("ignored_doneOnce", doneCount - frameDone, 32'd1);
        checkOutput("ignored_idle", {31'd0, busy}, 32'd0);

        // back-to-back with start held high
        @(negedge clock);
        regAddr = 8'h11;
        regData = 8'h01;
        start   = 1'b1;
        @(posedge clock);
        #2;
        snapshot();
        @(negedge clock);
        regAddr = 8'h3A;
        regData = 8'h04;
        waitDone(frameDone + 1, "b2b1");
        for (int i = 0; i < 20 && busyRiseCycle <= doneCycle; i++) begin
            @(posedge clock);
            #2;
        end
        checkOutput("b2b_gap", busyRiseCycle - doneCycle, 32'd2);
        @(negedge clock);
        start = 1'b0;
        waitDone(frameDone + 2, "b2b2");
        checkFrame(frameRise, 8'h42, 8'h11, 8'h01, "b2b1");
        checkFrame(frameRise + 28, 8'h42, 8'h3A, 8'h04, "b2b2");
        checkOutput("b2b_starts", startSeen - frameStart, 32'd2);
        checkOutput("b2b_stops", stopSeen - frameStop, 32'd2);
        repeat (10) @(negedge clock);

        // ACK slot of PH2 answered with 1
        ackBase = oeFallCount;
        ackMode = 1'b1;
        applyStimulus(8'h55, 8'hA5, "ack");
        waitTicks(50);
        checkOutput("ack_nackEarly", {31'd0, nack}, 32'd0);
        for (int i = 0; i < 3000 && (oeFallCount - ackBase) < 3; i++) begin
            @(posedge clock);
            #2;
        end
        checkOutput("ack_nackAfterPh2", {31'd0, nack}, {31'd0, ExpNack});
        waitDone(frameDone + 1, "ack");
        checkOutput("ack_nackAtDone", {31'd0, nackAtDone}, {31'd0, ExpNack});
        checkFrame(frameRise, 8'h42, 8'h55, 8'hA5, "ack");
        ackMode = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("ack_nackHeld", {31'd0, nack}, {31'd0, ExpNack});
        applyStimulus(8'h01, 8'h02, "ackClear");
        checkOutput("ack_nackCleared", {31'd0, nack}, 32'd0);
        waitDone(frameDone + 1, "ackClear");
        checkOutput("ackClear_nack", {31'd0, nackAtDone}, 32'd0);
        repeat (5) @(negedge clock);

        // reset mid-PH1 then a clean frame
        applyStimulus(8'h0A, 8'h5C, "abort");
        waitTicks(20);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #2;
        checkOutput("abort_lines", {26'd0, sioc, siod, siodOe, busy, done, nack}, {26'd0, 6'b111000});
        @(negedge clock);
        reset = 1'b0;
        repeat (150) @(negedge clock);
        checkOutput("abort_noDone", doneCount - frameDone, 32'd0);
        applyStimulus(8'h0A, 8'h5C, "afterAbort");
        waitDone(frameDone + 1, "afterAbort");
        checkOutput("afterAbort_ticks", doneTick - frameTick, 32'd116);
        checkFrame(frameRise, 8'h42, 8'h0A, 8'h5C, "afterAbort");

        repeat (5) @(negedge clock);
        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/sccb_write_master.md
# sccb_write_master

Serial camera-control (SCCB) 3-phase write master for the camera configuration path. It consumes the divided clock produced by the camera clock divider as a bit-rate timebase and drives SIOC/SIOD to write one 8-bit register per request. It is placed between the camera init sequencer, which issues register/data pairs, and the sensor pins.

## Interface
- `DeviceId`, default 8'h42, is the 8-bit sensor write address sent in phase 1. Bit 0 must be 0.
- `clock` in 1: system clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `divClock` in 1: divided clock from the divider, synchronous to `clock`. Its rising edges define ticks.
- `start` in 1: write request, sampled only in IDLE.
- `regAddr` in 8: register address, latched on an accepted `start`.
- `regData` in 8: register data, latched on an accepted `start`.
- `siodIn` in 1: SIOD pad input, used only for ACK checking.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle pulse when a transfer completes.
- `nack` out 1: sticky error flag for the last transfer.
- `sioc` out 1: SCCB clock line.
- `siod` out 1: SCCB data value.
- `siodOe` out 1: SIOD output enable. 0 means the line is released.

## Operation
- **Tick:** `tick = divClock & ~divClockQ`. `divClockQ` is a register of `divClock` and resets to 0. One clock-enable pulse occurs per `divClock` rising edge.
- **States:** IDLE, START, PH1, PH2, PH3, STOP, FIN.
- **Quarter counter:** a 2-bit counter `q` advances on each tick in every state except IDLE/FIN. A bit counter `b` (0..8) advances when `q` wraps from 3 to 0.
- **IDLE:** `sioc=1`, `siod=1`, `siodOe=1`.
  - `start=1` latches `regAddr`/`regData`, clears `nack`, sets `busy` next cycle, and moves to START with `q=0`.
  - `start` is ignored in every other state.
- **START (4 ticks):**
  - q0: `sioc=1`, `siod=1`.
  - q1, q2: `siod=0`, so SIOD falls while SIOC is high.
  - q3: `sioc=0`.
  - Then PH1.
- **PHn (9 bits × 4 ticks each):**
  - Bytes: PH1 sends `DeviceId`, PH2 sends `regAddr`, PH3 sends `regData`. Each byte is sent MSB first for b=0..7.
  - q0: `sioc=0`.
  - q1: drive the bit on `siod`. For b=8 (don't-care/ACK bit), set `siodOe=0` and `siod=1`.
  - q2, q3: `sioc=1`.
  - After b=8 q3, go to the next phase (PH3 is followed by STOP) with `b=0` and `siodOe=1`.
- **STOP (4 ticks):**
  - q0, q1: `sioc=0`, `siod=0`.
  - q2: `sioc=1`.
  - q3: `siod=1`.
  - Then FIN.
- **FIN (1 clock, no tick needed):** `done=1`, `busy=0`, return to IDLE.
- **Reset in any state:** next edge forces IDLE and idle line levels. No STOP condition is generated and no `done` pulse is produced. The `nack` flag is cleared.

## Timing
- **Reset values:** `sioc=1`, `siod=1`, `siodOe=1`, `busy=0`, `done=0`, `nack=0`.
- **Start acceptance:** `busy` rises 1 cycle after an accepted `start`.
- **Line updates:** all line changes occur 1 cycle after the `divClock` rising edge (tick detection is registered).
- **Transfer length:** 116 ticks (START 4 + 3×36 + STOP 4). `done` is asserted 1 cycle after the final STOP tick, in the same cycle that `busy` falls.
- **Back-to-back:** `start` held high in the FIN-following IDLE cycle is accepted. The minimum gap between transfers is 1 cycle of IDLE.
- **`divClock` stuck:** the FSM holds its state indefinitely. There is no timeout.

## Configuration
- `SCCB_ACK_CHECK_EN` defined:
  - During b=8 at q3 of each phase, `siodIn` is sampled.
  - If it is 1, `nack` is set and held until the next accepted `start` or `reset`.
  - The transfer still runs to completion.
- Not defined: `siodIn` is ignored and `nack` is constant 0.

## Test plan
- **Reset idle:** assert `reset` for 3 cycles with `divClock` toggling every 2 cycles -> `sioc=1`, `siod=1`, `siodOe=1`, `busy=0`, `done=0`, `nack=0` throughout.
- **Single write:** `regAddr=8'h12`, `regData=8'h80`, 1-cycle `start`, `divClock` period 4 cycles:
  - SIOD falls with SIOC high.
  - Bits 0x42, 0x12, 0x80 are captured MSB-first on SIOC rising edges.
  - `siodOe=0` for each b=8.
  - STOP is seen.
  - `done` pulses exactly once, 116 ticks after the first tick.
- **Ignored start:** pulse `start` with `regAddr=8'hFF` mid-PH2 -> transmitted bytes are unchanged and one `done` is produced.
- **Back-to-back:** hold `start` high for two requests (`8'h11/8'h01`, then `8'h3A/8'h04`) -> two complete frames, with exactly 1 IDLE cycle between `done` and `busy` re-rising.
- **ACK check** (`SCCB_ACK_CHECK_EN` defined), `siodIn=1` during the PH2 ack slot:
  - `nack=1` after PH2 q3 and held through `done`.
  - `nack` clears on the next `start`.
  - Without the macro, `nack` stays 0.
- **Reset mid-PH1:** assert `reset` for 1 cycle -> lines return to idle on the next edge, with no `done` pulse. A subsequent `start` produces a correct full frame.
